// File: rtl/imgk_pkg.sv
// Shared image-kernel package: direction codes, packed pixel-word field layout
// and the tan(22.5 deg) shift approximation used by gradient quantisers.
package imgk_pkg;

    // Quantised gradient orientation codes carried in the pixel word
    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_e;

    // Default widths of the gradient inputs and the packed pixel word
    localparam int unsigned PIX_GWIDTH    = 12;
    localparam int unsigned PIX_DWIDTH    = 16;
    localparam int unsigned PIX_MAG_WIDTH = 12;
    localparam int unsigned PIX_DIR_WIDTH = 2;

    // Field positions: magnitude at the bottom, direction above it, mask in the MSB
    localparam int unsigned PIX_MAG_LSB   = 0;

    // a * tan(22.5 deg) ~= a * (1/4 + 1/8 + 1/32) = a * 0.40625
    function automatic logic [31:0] tan22_5(input logic [31:0] a);
        return (a >> 2) + (a >> 3) + (a >> 5);
    endfunction

endpackage

// File: rtl/grad_pack_if.sv
// Pixel stream interface for grad_pack: Sobel-side input and NMS-side output.
// Carries edge_count only when GRAD_PACK_STATS_EN is defined.
interface grad_pack_if #(
    parameter int unsigned GWIDTH    = 12,
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned MAG_WIDTH = 12
);
    logic                        in_valid;
    logic                        sof;
    logic                        eol;
    logic signed [GWIDTH-1:0]    gx;
    logic signed [GWIDTH-1:0]    gy;
    logic [MAG_WIDTH-1:0]        thresh;
    logic                        out_valid;
    logic                        out_sof;
    logic                        out_eol;
    logic [DWIDTH-1:0]           data_out;
`ifdef GRAD_PACK_STATS_EN
    logic [31:0]                 edge_count;

    modport master (
        output in_valid, sof, eol, gx, gy, thresh,
        input  out_valid, out_sof, out_eol, data_out, edge_count
    );

    modport slave (
        input  in_valid, sof, eol, gx, gy, thresh,
        output out_valid, out_sof, out_eol, data_out, edge_count
    );
`else
    modport master (
        output in_valid, sof, eol, gx, gy, thresh,
        input  out_valid, out_sof, out_eol, data_out
    );

    modport slave (
        input  in_valid, sof, eol, gx, gy, thresh,
        output out_valid, out_sof, out_eol, data_out
    );
`endif
endinterface

// File: rtl/grad_dir_quant.sv
// Combinational quantiser: gradient magnitudes, their tan(22.5) scaled
// versions and sign bits -> one of four orientation codes.
module grad_dir_quant
    import imgk_pkg::*;
#(
    parameter int unsigned GWIDTH = PIX_GWIDTH
) (
    input  logic [GWIDTH-1:0] ax,
    input  logic [GWIDTH-1:0] ay,
    input  logic [GWIDTH-1:0] tx,
    input  logic [GWIDTH-1:0] ty,
    input  logic              sx,
    input  logic              sy,
    output logic [1:0]        dir_c
);

    // Near-horizontal first, then near-vertical, else pick diagonal by sign agreement
    always_comb begin
        dir_c = DIR_0;
        if (ay <= tx) begin
            dir_c = DIR_0;
        end else if (ax <= ty) begin
            dir_c = DIR_90;
        end else if (sx == sy) begin
            dir_c = DIR_45;
        end else begin
            dir_c = DIR_135;
        end
    end

endmodule

// File: rtl/grad_pack.sv
// grad_pack: three-stage pipeline turning signed Sobel (gx, gy) pairs into the
// packed NMS pixel word {mask, pad, dir, mag}. Latency is exactly 3 cycles,
// no backpressure. Define GRAD_PACK_STATS_EN to add a per-frame count of
// candidate edge pixels on edge_count.
module grad_pack
    import imgk_pkg::*;
#(
    parameter int unsigned GWIDTH    = PIX_GWIDTH,
    parameter int unsigned DWIDTH    = PIX_DWIDTH,
    parameter int unsigned MAG_WIDTH = PIX_MAG_WIDTH,
    parameter int unsigned DIR_WIDTH = PIX_DIR_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    grad_pack_if.slave bus
);

    localparam int unsigned SWIDTH   = GWIDTH + 1;
    localparam int unsigned MAG_MAX  = (1 << MAG_WIDTH) - 1;
    localparam int unsigned MAG_LSB  = PIX_MAG_LSB;
    localparam int unsigned DIR_LSB  = MAG_LSB + MAG_WIDTH;
    localparam int unsigned MASK_BIT = DWIDTH - 1;

    // ---------------- Stage 1: absolute values, signs, threshold select
    logic                 v1, sof1, eol1, sx1, sy1;
    logic [GWIDTH-1:0]    ax1, ay1;
    logic [MAG_WIDTH-1:0] thr_q, thr1;
    logic [GWIDTH-1:0]    ax_c, ay_c;
    logic [MAG_WIDTH-1:0] thr_sel_c;
    logic                 load_thr_c;

    // Two's complement magnitude; the most negative input maps to 2^(GWIDTH-1)
    assign ax_c       = bus.gx[GWIDTH-1] ? GWIDTH'(~bus.gx + 1'b1) : GWIDTH'(bus.gx);
    assign ay_c       = bus.gy[GWIDTH-1] ? GWIDTH'(~bus.gy + 1'b1) : GWIDTH'(bus.gy);
    assign load_thr_c = bus.in_valid & bus.sof;
    // The sof pixel itself already uses the new threshold
    assign thr_sel_c  = load_thr_c ? bus.thresh : thr_q;

    // S1 register: capture |gx|, |gy|, signs, per-pixel threshold and frame threshold
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            sof1  <= 1'b0;
            eol1  <= 1'b0;
            sx1   <= 1'b0;
            sy1   <= 1'b0;
            ax1   <= '0;
            ay1   <= '0;
            thr1  <= '0;
            thr_q <= '0;
        end else begin
            v1   <= bus.in_valid;
            sof1 <= bus.in_valid & bus.sof;
            eol1 <= bus.in_valid & bus.eol;
            sx1  <= bus.gx[GWIDTH-1];
            sy1  <= bus.gy[GWIDTH-1];
            ax1  <= ax_c;
            ay1  <= ay_c;
            thr1 <= thr_sel_c;
            if (load_thr_c) begin
                thr_q <= bus.thresh;
            end
        end
    end

    // ---------------- Stage 2: saturated L1 magnitude, tan(22.5) thresholds
    logic                 v2, sof2, eol2, sx2, sy2;
    logic [GWIDTH-1:0]    ax2, ay2, tx2, ty2;
    logic [MAG_WIDTH-1:0] mag2, thr2;
    logic [SWIDTH-1:0]    sum_c;
    logic [MAG_WIDTH-1:0] mag_c;
    logic [GWIDTH-1:0]    tx_c, ty_c;

    assign sum_c = {1'b0, ax1} + {1'b0, ay1};
    assign mag_c = (sum_c > SWIDTH'(MAG_MAX)) ? '1 : MAG_WIDTH'(sum_c);
    assign tx_c  = GWIDTH'(tan22_5(32'(ax1)));
    assign ty_c  = GWIDTH'(tan22_5(32'(ay1)));

    // S2 register: magnitude and scaled components for the direction compare
    always_ff @(posedge clk) begin
        if (rst) begin
            v2   <= 1'b0;
            sof2 <= 1'b0;
            eol2 <= 1'b0;
            sx2  <= 1'b0;
            sy2  <= 1'b0;
            ax2  <= '0;
            ay2  <= '0;
            tx2  <= '0;
            ty2  <= '0;
            mag2 <= '0;
            thr2 <= '0;
        end else begin
            v2   <= v1;
            sof2 <= sof1;
            eol2 <= eol1;
            sx2  <= sx1;
            sy2  <= sy1;
            ax2  <= ax1;
            ay2  <= ay1;
            tx2  <= tx_c;
            ty2  <= ty_c;
            mag2 <= mag_c;
            thr2 <= thr1;
        end
    end

    // ---------------- Stage 3: direction, mask and packing
    logic              out_valid_q, out_sof_q, out_eol_q;
    logic [DWIDTH-1:0] data_q;
    logic [1:0]        dir_c;
    logic              mask_c;
    logic [DWIDTH-1:0] word_c;

    grad_dir_quant #(
        .GWIDTH (GWIDTH)
    ) u_dir (
        .ax    (ax2),
        .ay    (ay2),
        .tx    (tx2),
        .ty    (ty2),
        .sx    (sx2),
        .sy    (sy2),
        .dir_c (dir_c)
    );

    // A zero magnitude is never an edge, even with a zero threshold
    assign mask_c = (mag2 >= thr2) && (mag2 != '0);

    // Assemble the NMS pixel word; unused middle bits stay zero
    always_comb begin
        word_c                       = '0;
        word_c[MAG_LSB +: MAG_WIDTH] = mag2;
        word_c[DIR_LSB +: DIR_WIDTH] = DIR_WIDTH'(dir_c);
        word_c[MASK_BIT]             = mask_c;
    end

    // S3 register: outputs; data holds its last value across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            data_q      <= '0;
        end else begin
            out_valid_q <= v2;
            out_sof_q   <= sof2;
            out_eol_q   <= eol2;
            if (v2) begin
                data_q <= word_c;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.data_out  = data_q;

`ifdef GRAD_PACK_STATS_EN
    logic [31:0] cnt_q;
    logic [31:0] edge_q;

    // Count masked output pixels; a new frame publishes the count and restarts it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            edge_q <= '0;
        end else if (out_valid_q) begin
            if (out_sof_q) begin
                edge_q <= cnt_q;
                cnt_q  <= 32'(data_q[MASK_BIT]);
            end else if (data_q[MASK_BIT] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign bus.edge_count = edge_q;
`endif

endmodule

// File: tb/tb_grad_pack.sv
// Self-checking bench for grad_pack: queue-based reference model checked every
// cycle, plus literal expectations for hand-computed pixels.
module tb_grad_pack;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    grad_pack_if #(.GWIDTH(12), .DWIDTH(16), .MAG_WIDTH(12)) bus ();

    grad_pack #(
        .GWIDTH    (12),
        .DWIDTH    (16),
        .MAG_WIDTH (12),
        .DIR_WIDTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic [15:0] word;
        bit          s;
        bit          e;
    } exp_t;

    typedef struct {
        int          due;
        logic [15:0] word;
        int          id;
    } lit_t;

    exp_t q[$];
    lit_t lq[$];
    int   thr_m = 0;
    int   run_m = 0;
    int   ec_m = 0;

    // Reference: output word from the arithmetic definition of the block
    function automatic logic [15:0] model_word(input int x, input int y, input int th);
        int ax, ay, s, m, tx, ty, d;
        bit k;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        s  = ax + ay;
        m  = (s > 4095) ? 4095 : s;
        tx = ax / 4 + ax / 8 + ax / 32;
        ty = ay / 4 + ay / 8 + ay / 32;
        if (ay <= tx)                d = 0;
        else if (ax <= ty)           d = 2;
        else if ((x < 0) == (y < 0)) d = 1;
        else                         d = 3;
        k = (m >= th) && (m != 0);
        return 16'((k ? 32'h8000 : 32'h0) + d * 4096 + m);
    endfunction

    task automatic drive(input bit v, input bit s, input bit e,
                         input int x, input int y, input int th);
        exp_t ex;
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.sof      = s;
        bus.eol      = e;
        bus.gx       = 12'(x);
        bus.gy       = 12'(y);
        bus.thresh   = 12'(th);
        if (v) begin
            if (s) thr_m = th;
            ex.due  = cyc + 3;
            ex.word = model_word(x, y, thr_m);
            ex.s    = s;
            ex.e    = e;
            q.push_back(ex);
        end
    endtask

    task automatic drive_lit(input bit s, input bit e, input int x, input int y,
                             input int th, input logic [15:0] lit, input int id);
        lit_t l;
        drive(1'b1, s, e, x, y, th);
        l.due  = cyc + 3;
        l.word = lit;
        l.id   = id;
        lq.push_back(l);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        // Anything not yet on the outputs is lost
        while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
        while (lq.size() > 0 && lq[lq.size()-1].due > cyc) void'(lq.pop_back());
        thr_m = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.data_out !== 16'h0) begin
            n_fail++;
            $display("FAIL post_reset: valid=%b data=%h, required valid=0 data=0000",
                     bus.out_valid, bus.data_out);
        end
    endtask

    // Per-cycle comparison against the model and the literal expectations
    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        if (chk_en) begin
            ev = (q.size() > 0) && (q[0].due == cyc);
            n_tests++;
            if (bus.out_valid !== ev) begin
                n_fail++;
                $display("FAIL out_valid cyc=%0d: got %b, required %b", cyc, bus.out_valid, ev);
            end
`ifdef GRAD_PACK_STATS_EN
            n_tests++;
            if (bus.edge_count !== 32'(ec_m)) begin
                n_fail++;
                $display("FAIL edge_count cyc=%0d: got %0d, required %0d", cyc, bus.edge_count, ec_m);
            end
`endif
            if (ev) begin
                e = q.pop_front();
                n_tests++;
                if ({bus.out_sof, bus.out_eol, bus.data_out} !== {e.s, e.e, e.word}) begin
                    n_fail++;
                    $display("FAIL pixel cyc=%0d: got sof=%b eol=%b data=%h, required sof=%b eol=%b data=%h",
                             cyc, bus.out_sof, bus.out_eol, bus.data_out, e.s, e.e, e.word);
                end
                if (e.s) begin
                    ec_m  = run_m;
                    run_m = e.word[15] ? 1 : 0;
                end else if (e.word[15]) begin
                    run_m++;
                end
            end
            if (lq.size() > 0 && lq[0].due == cyc) begin
                n_tests++;
                if (bus.out_valid !== 1'b1 || bus.data_out !== lq[0].word) begin
                    n_fail++;
                    $display("FAIL literal_%0d: got valid=%b data=%h, required valid=1 data=%h",
                             lq[0].id, bus.out_valid, bus.data_out, lq[0].word);
                end
                void'(lq.pop_front());
            end
        end
        if (rst) begin
            run_m = 0;
            ec_m  = 0;
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
        bus.eol      = 1'b0;
        bus.gx       = '0;
        bus.gy       = '0;
        bus.thresh   = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.out_valid, bus.out_sof, bus.out_eol} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 000", {bus.out_valid, bus.out_sof, bus.out_eol});
        end
        n_tests++;
        if (bus.data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0000", bus.data_out);
        end

        // Hand-computed pixels, back to back
        drive_lit(1, 0,   100,     0,   50, 16'h8064, 1);
        drive_lit(1, 0,   -40,   -40,  100, 16'h1050, 2);
        drive_lit(0, 0,    40,   -40,    0, 16'h3050, 3);  // thresh ignored without sof
        drive_lit(1, 0, -2048, -2048, 4095, 16'h9FFF, 4);  // saturation
        drive_lit(1, 1,     0,     0,    0, 16'h0000, 5);  // zero never masks; sof+eol
        drive_lit(1, 0,     0,   100,  100, 16'hA064, 6);  // vertical, mag == thr
        idle(2);

        // Threshold swap mid-stream: the pixel before the sof keeps 10
        drive_lit(1, 0,  50, 0,  10, 16'h8032, 7);
        drive_lit(0, 1,  50, 0, 200, 16'h8032, 8);
        drive_lit(1, 0,  50, 0, 200, 16'h0032, 9);
        drive_lit(0, 0, 250, 0,   0, 16'h80FA, 10);
        idle(4);

        // Random stream with bubbles and a mid-frame reset
        for (int i = 0; i < 240; i++) begin
            if (i == 120) do_reset();
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 4095)) - 2048,
                  int'($urandom_range(0, 4095)) - 2048,
                  int'($urandom_range(0, 3000)));
        end
        idle(5);

`ifdef GRAD_PACK_STATS_EN
        // 64-pixel frame with 17 edges, then a new frame publishes the count
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, (i == 0), (i == 63), (i < 17) ? 150 : 20, 0, 100);
        end
        drive(1'b1, 1'b1, 1'b0, 20, 0, 100);
        idle(5);
        n_tests++;
        if (bus.edge_count !== 32'd17) begin
            n_fail++;
            $display("FAIL stats_frame: got %0d, required 17", bus.edge_count);
        end
`endif

        idle(2);
        n_tests++;
        if (q.size() != 0 || lq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, required 0/0", q.size(), lq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
